interrupt_demo_irq_slave: RTL and testbench
===========================================

// Module: interrupt_demo_irq_slave
// PURPOSE
//  AXI4-Lite register slave on port S00_AXI of the interrupt_demo IP; the AXI master VIP drives it directly.
//  Holds a scratch register, a down-counting timer and edge-detected external IRQ inputs.
//  Drives one level interrupt line to the PS/interrupt controller.
//  Offsets 0x0..0xC are plain RW, so sequential write/read-back of 1..4 at 0x0..0xC always matches.
// PARAMETERS
//  C_S_AXI_DATA_WIDTH  32  AXI data width; only 32 supported
//  C_S_AXI_ADDR_WIDTH  5   byte address width (8 word registers, 0x00-0x1C)
//  IRQ_IN_WIDTH        4   number of external edge-triggered sources (1..31)
// PORTS
//  ACLK            in   1     sole clock; all logic rising-edge
//  ARESET          in   1     asynchronous, active-high reset
//  S_AXI_AWADDR    in   5     write address
//  S_AXI_AWVALID   in   1     /  S_AXI_AWREADY  out 1
//  S_AXI_WDATA     in   32    write data
//  S_AXI_WSTRB     in   4     byte enables
//  S_AXI_WVALID    in   1     /  S_AXI_WREADY   out 1
//  S_AXI_BRESP     out  2     always 2'b00 (OKAY)
//  S_AXI_BVALID    out  1     /  S_AXI_BREADY   in  1
//  S_AXI_ARADDR    in   5     read address
//  S_AXI_ARVALID   in   1     /  S_AXI_ARREADY  out 1
//  S_AXI_RDATA     out  32    read data
//  S_AXI_RRESP     out  2     always 2'b00
//  S_AXI_RVALID    out  1     /  S_AXI_RREADY   in  1
//  irq_in          in   IRQ_IN_WIDTH  async-free (ACLK-synchronous) sources, rising edge sets status
//  irq             out  1     level interrupt = |(STATUS & ENABLE), registered
// BEHAVIOUR
//  Reset: all READY/VALID outputs 0, RDATA 0, irq 0, all registers 0, timer count 0, edge history 0.
//  Map (word idx = ADDR[4:2]): 0 SCRATCH RW | 1 LOAD RW | 2 ENABLE RW[IRQ_IN_WIDTH:0] | 3 CTRL RW[1:0]
//   (bit0 EN, bit1 AUTO) | 4 STATUS W1C[IRQ_IN_WIDTH:0] (bit0 timer, bit k = irq_in[k-1]) | 5 COUNT RO | 6,7 read 0.
//  Write: AW and W captured independently (AWREADY/WREADY high 1 cycle per beat, each held low once captured);
//   register update on the cycle both are held; BVALID asserts next cycle, held until BREADY; no new AW/W
//   accepted while BVALID=1. WSTRB applied per byte on RW regs; on STATUS a set byte-lane bit=1 clears.
//   Writes to RO/unmapped ignored, still BRESP OKAY.
//  Read: ARREADY=1 when RVALID=0 and ARVALID=1, single-cycle pulse; RDATA registered, RVALID next cycle,
//   held with stable RDATA until RREADY. One outstanding read, one outstanding write; read and write concurrent.
//  Timer: CTRL.EN 0->1 loads COUNT<=LOAD. While EN: COUNT!=0 -> COUNT-1; COUNT==0 -> set STATUS[0] and
//   AUTO ? COUNT<=LOAD : EN<=0. LOAD=0 with AUTO fires every cycle. LOAD writes while running take effect at
//   next reload. EN 1->0 freezes COUNT.
//  Edge: STATUS[k] set when irq_in[k-1]=1 and previous sample 0. Set and W1C same cycle -> set wins.
//  irq registered: one cycle after STATUS/ENABLE change. ENABLE write alone never alters STATUS.
//  Reset mid-transaction: outstanding BVALID/RVALID dropped immediately; no register write completes.
// STRUCTURE
//  interrupt_demo_pkg: register index localparams (REG_SCRATCH..REG_COUNT), CTRL bit positions, RESP_OKAY.
//  Sub-module interrupt_demo_irq_timer (EN/AUTO/LOAD in, COUNT and expire pulse out).
//  Top: AXI write/read channel FSMs, register file, edge detect, STATUS/irq logic.
// TESTING
//  Write 1,2,3,4 to 0x0,0x4,0x8,0xC, read back -> 1,2,3,4, BRESP/RRESP=0.
//  WSTRB=4'b0010 data 0xAABBCCDD to 0x0 (was 0x1) -> reads 0x0000CC01.
//  LOAD=3, ENABLE=1, CTRL=1 -> STATUS[0] sets 4 cycles after write completes, irq 1 cycle later, EN reads 0.
//  CTRL=3, LOAD=2 -> STATUS[0] re-fires every 3 cycles; write STATUS=1 same cycle as expiry -> stays 1.
//  Pulse irq_in[1] with ENABLE=0 -> STATUS=0x4, irq=0; then ENABLE=0x4 -> irq=1; W1C 0x4 -> irq=0.
//  AW 5 cycles before W, BREADY held low 10 cycles; also ARESET during held RVALID -> VALIDs to 0, regs 0.

Source files
------------

// File: rtl/interrupt_demo_pkg.sv
// Shared constants for the interrupt_demo AXI4-Lite register slave.
package interrupt_demo_pkg;

  // Word index = ADDR[4:2]
  localparam logic [2:0] REG_SCRATCH = 3'd0;
  localparam logic [2:0] REG_LOAD    = 3'd1;
  localparam logic [2:0] REG_ENABLE  = 3'd2;
  localparam logic [2:0] REG_CTRL    = 3'd3;
  localparam logic [2:0] REG_STATUS  = 3'd4;
  localparam logic [2:0] REG_COUNT   = 3'd5;

  // CTRL bit positions
  localparam int CTRL_EN   = 0;
  localparam int CTRL_AUTO = 1;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  // Merge data into old value on byte lanes whose strobe is set.
  function automatic logic [31:0] apply_strb(input logic [31:0] old,
                                             input logic [31:0] data,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[b*8 +: 8] = data[b*8 +: 8];
    return r;
  endfunction

endpackage

// File: rtl/interrupt_demo_irq_timer.sv
// Down-counting timer: start loads LOAD, counts to zero, then expires and
// either reloads (auto) or leaves the count at zero for the owner to stop.
module interrupt_demo_irq_timer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         en,
  input  logic         auto_reload,
  input  logic [W-1:0] load,
  output logic [W-1:0] count,
  output logic         expire
);

  // Expiry is the cycle the running counter sits at zero; a start that
  // same cycle takes priority since EN was just turned on.
  assign expire = en & ~start & (count == '0);

  // Count register: load on start, decrement while running, reload on auto expiry
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  count <= '0;
    else if (start)           count <= load;
    else if (en) begin
      if (count != '0)        count <= count - 1'b1;
      else if (auto_reload)   count <= load;
    end
  end

endmodule

// File: rtl/interrupt_demo_irq_slave.sv
// AXI4-Lite register slave for interrupt_demo: scratch, timer, edge-detected
// external sources and a registered level interrupt output.
module interrupt_demo_irq_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int IRQ_IN_WIDTH       = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic [IRQ_IN_WIDTH-1:0]         irq_in,
  output logic                            irq
);
  import interrupt_demo_pkg::*;

  localparam int SW = IRQ_IN_WIDTH + 1;   // status/enable width: timer + sources

  logic [31:0]             scratch, load_r, ctrl_r, count_r;
  logic [SW-1:0]           enable_r, status;
  logic [IRQ_IN_WIDTH-1:0] irq_prev, irq_rise;

  logic        aw_got, w_got, wr_fire;
  logic [2:0]  wr_idx;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;

  logic [31:0] enable_ext, status_ext, enable_nxt, ctrl_nxt, w1c, rd_mux;
  logic        wr_ctrl, wr_status, timer_start, timer_expire;

  assign S_AXI_BRESP = RESP_OKAY;
  assign S_AXI_RRESP = RESP_OKAY;

  // Both halves of a write are parked until the response slot is free.
  assign wr_fire   = aw_got & w_got & ~S_AXI_BVALID;
  assign wr_ctrl   = wr_fire & (wr_idx == REG_CTRL);
  assign wr_status = wr_fire & (wr_idx == REG_STATUS);
  assign irq_rise  = irq_in & ~irq_prev;

  // Widened register views, write merges and read mux
  always_comb begin
    enable_ext = '0;
    enable_ext[SW-1:0] = enable_r;
    status_ext = '0;
    status_ext[SW-1:0] = status;
    enable_nxt  = apply_strb(enable_ext, wr_data, wr_strb);
    ctrl_nxt    = apply_strb(ctrl_r, wr_data, wr_strb);
    w1c         = wr_status ? apply_strb('0, wr_data, wr_strb) : '0;
    timer_start = wr_ctrl & ctrl_nxt[CTRL_EN] & ~ctrl_r[CTRL_EN];
    rd_mux = '0;
    case (S_AXI_ARADDR[4:2])
      REG_SCRATCH: rd_mux = scratch;
      REG_LOAD:    rd_mux = load_r;
      REG_ENABLE:  rd_mux = enable_ext;
      REG_CTRL:    rd_mux = ctrl_r;
      REG_STATUS:  rd_mux = status_ext;
      REG_COUNT:   rd_mux = count_r;
      default:     rd_mux = '0;
    endcase
  end

  // Write address channel: one-cycle ready pulse, address held until the write fires
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      S_AXI_AWREADY <= 1'b0;
      aw_got        <= 1'b0;
      wr_idx        <= '0;
    end else begin
      S_AXI_AWREADY <= ~S_AXI_AWREADY & ~aw_got & S_AXI_AWVALID & ~S_AXI_BVALID;
      if (S_AXI_AWREADY & S_AXI_AWVALID) begin
        aw_got <= 1'b1;
        wr_idx <= S_AXI_AWADDR[4:2];
      end else if (wr_fire) begin
        aw_got <= 1'b0;
      end
    end
  end

  // Write data channel: same scheme, independent of AW ordering
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      S_AXI_WREADY <= 1'b0;
      w_got        <= 1'b0;
      wr_data      <= '0;
      wr_strb      <= '0;
    end else begin
      S_AXI_WREADY <= ~S_AXI_WREADY & ~w_got & S_AXI_WVALID & ~S_AXI_BVALID;
      if (S_AXI_WREADY & S_AXI_WVALID) begin
        w_got   <= 1'b1;
        wr_data <= S_AXI_WDATA;
        wr_strb <= S_AXI_WSTRB;
      end else if (wr_fire) begin
        w_got <= 1'b0;
      end
    end
  end

  // Write response: raised the cycle after the register update, held for BREADY
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET)            S_AXI_BVALID <= 1'b0;
    else if (wr_fire)      S_AXI_BVALID <= 1'b1;
    else if (S_AXI_BREADY) S_AXI_BVALID <= 1'b0;
  end

  // Read channel: one outstanding read, RDATA frozen while RVALID waits
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
    end else begin
      S_AXI_ARREADY <= ~S_AXI_ARREADY & ~S_AXI_RVALID & S_AXI_ARVALID;
      if (S_AXI_ARREADY & S_AXI_ARVALID) begin
        S_AXI_RVALID <= 1'b1;
        S_AXI_RDATA  <= rd_mux;
      end else if (S_AXI_RREADY) begin
        S_AXI_RVALID <= 1'b0;
      end
    end
  end

  // Register file, STATUS set/clear, edge history and registered irq.
  // Upper CTRL bits are plain storage; only EN/AUTO drive the timer.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      scratch  <= '0;
      load_r   <= '0;
      enable_r <= '0;
      ctrl_r   <= '0;
      status   <= '0;
      irq_prev <= '0;
      irq      <= 1'b0;
    end else begin
      if (wr_fire && wr_idx == REG_SCRATCH) scratch  <= apply_strb(scratch, wr_data, wr_strb);
      if (wr_fire && wr_idx == REG_LOAD)    load_r   <= apply_strb(load_r, wr_data, wr_strb);
      if (wr_fire && wr_idx == REG_ENABLE)  enable_r <= enable_nxt[SW-1:0];
      if (wr_ctrl)
        ctrl_r <= ctrl_nxt;
      else if (timer_expire && !ctrl_r[CTRL_AUTO])
        ctrl_r[CTRL_EN] <= 1'b0;
      // Set sources are ORed after the clear so a same-cycle event survives
      status   <= (status & ~w1c[SW-1:0]) | {irq_rise, timer_expire};
      irq_prev <= irq_in;
      irq      <= |(status & enable_r);
    end
  end

  interrupt_demo_irq_timer #(.W(32)) u_timer (
    .clk         (ACLK),
    .rst         (ARESET),
    .start       (timer_start),
    .en          (ctrl_r[CTRL_EN]),
    .auto_reload (ctrl_r[CTRL_AUTO]),
    .load        (load_r),
    .count       (count_r),
    .expire      (timer_expire)
  );

  logic unused_bits;
  assign unused_bits = ^{enable_nxt, w1c, S_AXI_AWADDR, S_AXI_ARADDR};

endmodule

// File: tb/tb_interrupt_demo_irq_slave.sv
// Directed bench for interrupt_demo_irq_slave: register access, strobes,
// timer one-shot/auto, edge sources, W1C, split AW/W, reset mid-read.
module tb_interrupt_demo_irq_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata, rd;
  logic [3:0]  wstrb, irq_in;
  logic [1:0]  bresp, rresp;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  interrupt_demo_irq_slave dut (
    .ACLK(clk), .ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .irq_in(irq_in), .irq(irq)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 right after the B handshake edge.
  task automatic axi_wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                        input int aw_dly, input int w_dly, input int b_hold);
    int n;
    fork
      begin
        int k;
        repeat (aw_dly) @(posedge clk);
        if (aw_dly > 0) #1;
        awaddr = a; awvalid = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (!awready && k < 50);
        chk("aw_handshake", {31'b0, awready}, 32'd1);
        @(posedge clk); #1 awvalid = 1'b0;
      end
      begin
        int k;
        repeat (w_dly) @(posedge clk);
        if (w_dly > 0) #1;
        wdata = d; wstrb = s; wvalid = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (!wready && k < 50);
        chk("w_handshake", {31'b0, wready}, 32'd1);
        @(posedge clk); #1 wvalid = 1'b0;
      end
    join
    n = 0;
    while (!bvalid && n < 50) begin @(negedge clk); n++; end
    chk("b_valid", {31'b0, bvalid}, 32'd1);
    repeat (b_hold) begin
      @(negedge clk);
      chk("b_held", {31'b0, bvalid}, 32'd1);
    end
    chk("bresp", {30'b0, bresp}, 32'd0);
    bready = 1'b1;
    @(posedge clk); #1 bready = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    axi_wr(a, d, 4'hF, 0, 0, 0);
  endtask

  // Called at posedge+1; returns at posedge+1.
  task automatic axi_rd(input logic [4:0] a, output logic [31:0] d);
    int n;
    araddr = a; arvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!arready && n < 50);
    chk("ar_handshake", {31'b0, arready}, 32'd1);
    @(posedge clk); #1 arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 50) begin @(negedge clk); n++; end
    chk("r_valid", {31'b0, rvalid}, 32'd1);
    chk("rresp", {30'b0, rresp}, 32'd0);
    d = rdata;
    rready = 1'b1;
    @(posedge clk); #1 rready = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] v;
    axi_rd(a, v);
    chk(tag, v, exp);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
    araddr = '0; arvalid = 0; rready = 0; irq_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {25'b0, awready, wready, bvalid, arready, rvalid, irq, 1'b0}, 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // Plain RW write/read-back
    wr(5'h00, 32'd1); wr(5'h04, 32'd2); wr(5'h08, 32'd3); wr(5'h0C, 32'd4);
    rd_chk("rb_scratch", 5'h00, 32'd1);
    rd_chk("rb_load",    5'h04, 32'd2);
    rd_chk("rb_enable",  5'h08, 32'd3);
    rd_chk("rb_ctrl",    5'h0C, 32'd4);

    // Byte strobe on lane 1 only
    axi_wr(5'h00, 32'hAABBCCDD, 4'b0010, 0, 0, 0);
    rd_chk("wstrb_lane1", 5'h00, 32'h0000CC01);

    // Unmapped read, RO write ignored
    rd_chk("unmapped_rd", 5'h18, 32'd0);
    wr(5'h14, 32'h55);
    rd_chk("count_ro", 5'h14, 32'd0);

    // One-shot timer: LOAD=3, status at 4th edge after the write, irq one later
    wr(5'h04, 32'd3); wr(5'h08, 32'd1);
    wr(5'h0C, 32'd1);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i == 4) chk("oneshot_irq_pre", {31'b0, irq}, 32'd0);
      if (i == 5) chk("oneshot_irq", {31'b0, irq}, 32'd1);
    end
    @(posedge clk); #1;
    rd_chk("oneshot_en_clr", 5'h0C, 32'd0);
    rd_chk("oneshot_status", 5'h10, 32'd1);
    rd_chk("oneshot_count",  5'h14, 32'd0);
    wr(5'h10, 32'd1);
    rd_chk("w1c_timer", 5'h10, 32'd0);
    @(negedge clk);
    chk("irq_after_w1c", {31'b0, irq}, 32'd0);
    @(posedge clk); #1;

    // Auto reload: LOAD=2 expires every 3 cycles
    wr(5'h04, 32'd2);
    wr(5'h0C, 32'd3);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      chk($sformatf("auto_expire_%0d", i), {31'b0, dut.timer_expire},
          (i == 2 || i == 5) ? 32'd1 : 32'd0);
    end
    // Land a STATUS W1C on an expiry edge: set must win
    @(posedge clk); @(posedge clk); @(posedge clk); #1;
    fork
      wr(5'h10, 32'd1);
      begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("set_beats_w1c", {31'b0, dut.status[0]}, 32'd1);
      end
    join
    // Stop: counter freezes mid-count
    wr(5'h0C, 32'd0);
    rd_chk("frozen_count", 5'h14, 32'd1);
    wr(5'h10, 32'd1);
    rd_chk("status_clr_stopped", 5'h10, 32'd0);
    rd_chk("frozen_count_2", 5'h14, 32'd1);

    // Edge source with ENABLE=0, then enable, then W1C
    wr(5'h08, 32'd0);
    irq_in = 4'b0010;
    @(posedge clk); #1 irq_in = 4'b0000;
    rd_chk("edge_status", 5'h10, 32'h4);
    @(negedge clk);
    chk("edge_irq_masked", {31'b0, irq}, 32'd0);
    @(posedge clk); #1;
    wr(5'h08, 32'h4);
    @(negedge clk);
    chk("edge_irq_enabled", {31'b0, irq}, 32'd1);
    @(posedge clk); #1;
    rd_chk("enable_keeps_status", 5'h10, 32'h4);
    wr(5'h10, 32'h4);
    @(negedge clk);
    chk("edge_irq_w1c", {31'b0, irq}, 32'd0);
    @(posedge clk); #1;

    // Held level sets once only
    irq_in = 4'b0001;
    repeat (3) @(posedge clk); #1;
    rd_chk("level_once", 5'h10, 32'h2);
    wr(5'h10, 32'h2);
    rd_chk("level_no_retrigger", 5'h10, 32'h0);
    irq_in = 4'b0000;

    // W1C with no strobes does nothing
    irq_in = 4'b0100;
    @(posedge clk); #1 irq_in = 4'b0000;
    axi_wr(5'h10, 32'h8, 4'b0000, 0, 0, 0);
    rd_chk("w1c_nostrb", 5'h10, 32'h8);
    axi_wr(5'h10, 32'h8, 4'b0001, 0, 0, 0);
    rd_chk("w1c_strb0", 5'h10, 32'h0);

    // AW five cycles ahead of W, BREADY held off ten cycles
    axi_wr(5'h00, 32'h12345678, 4'hF, 0, 5, 10);
    rd_chk("split_aw_w", 5'h00, 32'h12345678);

    // Reset while RVALID is held
    araddr = 5'h00; arvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!arready && n < 50);
    @(posedge clk); #1 arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 50) begin @(negedge clk); n++; end
    chk("rst_pre_rvalid", {31'b0, rvalid}, 32'd1);
    chk("rst_pre_rdata", rdata, 32'h12345678);
    rst = 1'b1;
    #1;
    chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    rd_chk("rst_scratch", 5'h00, 32'd0);
    rd_chk("rst_load",    5'h04, 32'd0);
    rd_chk("rst_count",   5'h14, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
